mandelbrot_frame_sequencer: RTL and testbench
=============================================

Name: mandelbrot_frame_sequencer

Overview:
- Sequences one full frame of Mandelbrot pixel computations through a single iteration engine.
- Walks an X/Y raster and generates the engine's cr/ci coordinates incrementally, adding a step per pixel and per row.
- Issues one run per pixel, captures the iteration count and delivers it to the framebuffer write port over a valid/ready handshake.
- Sits between the serial configuration register, the mandelbrot engine and the framebuffer.

Parameters:
- BITWIDTH, 11, width of the fixed-point coordinate, origin and step values.
- CTRWIDTH, 7, width of the engine iteration count.
- OUTW, 4, width of the pixel value sent to the framebuffer. OUTW <= CTRWIDTH.
- XW, 8, width of the column counter and of cfg_width.
- YW, 7, width of the row counter and of cfg_height.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a frame.
- abort  in  1  synchronous frame cancel.
- cfg_width  in  XW  pixels per row.
- cfg_height  in  YW  rows per frame.
- cr_origin  in  BITWIDTH  real coordinate of pixel (0,0).
- ci_origin  in  BITWIDTH  imaginary coordinate of pixel (0,0).
- cr_step  in  BITWIDTH  real increment per column.
- ci_step  in  BITWIDTH  imaginary increment per row.
- eng_run  out  1  single-cycle start pulse to the engine.
- eng_cr  out  BITWIDTH  real coordinate presented to the engine.
- eng_ci  out  BITWIDTH  imaginary coordinate presented to the engine.
- eng_done  in  1  single-cycle pulse: engine result valid.
- eng_ctr  in  CTRWIDTH  engine iteration count, valid while eng_done=1.
- pix_valid  out  1  pixel available to the framebuffer.
- pix_ready  in  1  framebuffer accepts the pixel.
- pix_data  out  OUTW  pixel value.
- pix_first  out  1  marks pixel (0,0); the framebuffer resets its write pointer on it.
- pix_last  out  1  marks the final pixel of the frame.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  single-cycle pulse when a frame completes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including eng_cr, eng_ci and pix_data.
  - x, y, the coordinate accumulators and all latched configuration registers cleared to 0.
- Every output is registered.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - On start=1, latch cfg_width, cfg_height, cr_origin, ci_origin, cr_step and ci_step. Inputs may change afterwards without effect.
  - Set x=0, y=0, cr_acc=cr_origin, ci_acc=ci_origin, then go to ISSUE.
  - If start=1 with cfg_width=0 or cfg_height=0: stay in IDLE, pulse frame_done on the next cycle, issue no pixels.
- ISSUE:
  - eng_run=1 for exactly this one cycle. This state always lasts one cycle, then goes to WAIT.
  - eng_cr=cr_acc and eng_ci=ci_acc. Both stay stable from ISSUE until the pixel leaves OUT.
- WAIT:
  - On eng_done=1, register pix_data=eng_ctr[OUTW-1:0], then go to OUT.
  - If eng_ctr >= 2^OUTW, pix_data saturates to all-ones.
  - eng_done arriving in any other state is ignored.
- OUT:
  - pix_valid=1.
  - pix_first=1 iff x=0 and y=0.
  - pix_last=1 iff x=W-1 and y=H-1 (latched W, H).
  - pix_data, pix_first and pix_last hold until pix_valid & pix_ready. pix_valid never drops without a handshake, except on abort.
  - On handshake with pix_last=1: go to IDLE and pulse frame_done=1 on the following cycle.
  - On handshake, otherwise, if x<W-1: x+=1 and cr_acc+=cr_step.
  - On handshake, otherwise, if x=W-1: x=0, y+=1, cr_acc=cr_origin and ci_acc+=ci_step.
  - After the coordinate update, go to ISSUE.
- Arithmetic: two's-complement add, wrapping modulo 2^BITWIDTH with no saturation. cr is therefore origin + x*step mod 2^BITWIDTH.
- Timing:
  - start at edge T gives eng_run high in cycle T+1.
  - A pixel handshake at edge T gives the next eng_run in cycle T+1.
  - eng_done at edge T gives pix_valid in cycle T+1.
- abort=1 in any state has priority over every other event:
  - Next state is IDLE.
  - pix_valid and eng_run go to 0; frame_done is not pulsed.
  - An engine result still in flight is later ignored.
- start while busy=1 is ignored.
- start and abort together in IDLE: abort wins and the FSM stays in IDLE.

Test Plan:
- W=2, H=2, cr_origin=0x700, ci_origin=0x100, cr_step=0x010, ci_step=0x020, engine model returns ctr=3 after 5 cycles, pix_ready=1 → exactly 4 eng_run pulses:
  - coordinates in order (0x700,0x100), (0x710,0x100), (0x700,0x120), (0x710,0x120);
  - pix_data=3 on every pixel;
  - pix_first on pixel 0 only, pix_last on pixel 3 only;
  - one frame_done, one cycle after the last handshake.
- Wrap: cr_origin=0x7F8, cr_step=0x010, W=2 → second eng_cr=0x008.
- Backpressure: pix_ready held 0 for 10 cycles → pix_valid and pix_data stable, no new eng_run until the handshake.
- Saturation: OUTW=4, eng_ctr=0x7F → pix_data=0xF.
- abort asserted in WAIT and again in OUT:
  - busy=0 next cycle, pix_valid=0, no frame_done;
  - a late eng_done is ignored;
  - a following start renders the frame from (0,0).
- cfg_width=0 with start → frame_done pulse next cycle, no eng_run.
- start pulsed mid-frame → ignored, pixel sequence unchanged.
- Async reset mid-frame → all outputs 0 immediately, busy=0.

Source files
------------

// File: rtl/mandelbrot_frame_sequencer.sv
// Frame sequencer: walks an X/Y raster, feeds one
// Mandelbrot engine and streams counts to the framebuffer.
module mandelbrot_frame_sequencer #(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 7,
  parameter int OUTW     = 4,
  parameter int XW       = 8,
  parameter int YW       = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [XW-1:0]       cfg_width,
  input  logic [YW-1:0]       cfg_height,
  input  logic [BITWIDTH-1:0] cr_origin,
  input  logic [BITWIDTH-1:0] ci_origin,
  input  logic [BITWIDTH-1:0] cr_step,
  input  logic [BITWIDTH-1:0] ci_step,
  output logic                eng_run,
  output logic [BITWIDTH-1:0] eng_cr,
  output logic [BITWIDTH-1:0] eng_ci,
  input  logic                eng_done,
  input  logic [CTRWIDTH-1:0] eng_ctr,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [OUTW-1:0]     pix_data,
  output logic                pix_first,
  output logic                pix_last,
  output logic                busy,
  output logic                frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t state;

  logic [XW-1:0]       x;
  logic [XW-1:0]       w_q;
  logic [YW-1:0]       y;
  logic [YW-1:0]       h_q;
  logic [BITWIDTH-1:0] cro_q;
  logic [BITWIDTH-1:0] crs_q;
  logic [BITWIDTH-1:0] cis_q;

  logic x_end;
  logic y_end;
  logic sat;
  logic empty;

  assign x_end = (x == w_q - XW'(1));
  assign y_end = (y == h_q - YW'(1));
  assign sat   = (eng_ctr >> OUTW) != '0;
  assign empty = (cfg_width == '0) ||
                 (cfg_height == '0);

  // eng_cr/eng_ci double as the coordinate accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      w_q        <= '0;
      h_q        <= '0;
      cro_q      <= '0;
      crs_q      <= '0;
      cis_q      <= '0;
      eng_run    <= 1'b0;
      eng_cr     <= '0;
      eng_ci     <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_first  <= 1'b0;
      pix_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      eng_run    <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        pix_valid <= 1'b0;
        pix_first <= 1'b0;
        pix_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              w_q    <= cfg_width;
              h_q    <= cfg_height;
              cro_q  <= cr_origin;
              crs_q  <= cr_step;
              cis_q  <= ci_step;
              x      <= '0;
              y      <= '0;
              eng_cr <= cr_origin;
              eng_ci <= ci_origin;
              if (empty) begin
                frame_done <= 1'b1;
              end else begin
                state   <= ISSUE;
                busy    <= 1'b1;
                eng_run <= 1'b1;
              end
            end
          end
          ISSUE: begin
            state <= WAIT;
          end
          WAIT: begin
            if (eng_done) begin
              state     <= OUT;
              pix_valid <= 1'b1;
              pix_data  <= sat ? '1 :
                           eng_ctr[OUTW-1:0];
              pix_first <= (x == '0) &&
                           (y == '0);
              pix_last  <= x_end && y_end;
            end
          end
          OUT: begin
            if (pix_ready) begin
              pix_valid <= 1'b0;
              pix_first <= 1'b0;
              pix_last  <= 1'b0;
              if (pix_last) begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                state   <= ISSUE;
                eng_run <= 1'b1;
                if (!x_end) begin
                  x      <= x + XW'(1);
                  eng_cr <= eng_cr + crs_q;
                end else begin
                  x      <= '0;
                  y      <= y + YW'(1);
                  eng_cr <= cro_q;
                  eng_ci <= eng_ci + cis_q;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_frame_sequencer.sv
// Bench for mandelbrot_frame_sequencer: pixel-index
// reference model, engine stand-in, random frames.
module tb_mandelbrot_frame_sequencer;

  localparam int BW = 11;
  localparam int CW = 7;
  localparam int OW = 4;
  localparam int XW = 8;
  localparam int YW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [XW-1:0] cfg_width = '0;
  logic [YW-1:0] cfg_height = '0;
  logic [BW-1:0] cr_origin = '0;
  logic [BW-1:0] ci_origin = '0;
  logic [BW-1:0] cr_step = '0;
  logic [BW-1:0] ci_step = '0;
  logic          eng_run;
  logic [BW-1:0] eng_cr;
  logic [BW-1:0] eng_ci;
  logic          eng_done = 1'b0;
  logic [CW-1:0] eng_ctr = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [OW-1:0] pix_data;
  logic          pix_first;
  logic          pix_last;
  logic          busy;
  logic          frame_done;

  mandelbrot_frame_sequencer #(
    .BITWIDTH(BW), .CTRWIDTH(CW), .OUTW(OW),
    .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cr_origin(cr_origin), .ci_origin(ci_origin),
    .cr_step(cr_step), .ci_step(ci_step),
    .eng_run(eng_run), .eng_cr(eng_cr),
    .eng_ci(eng_ci), .eng_done(eng_done),
    .eng_ctr(eng_ctr), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_first(pix_first), .pix_last(pix_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, exp);
    end
  endtask

  // engine stand-in controls
  int lat = 4;
  int ctr_val = 3;
  bit rand_eng = 1'b0;
  int eng_cnt = -1;
  int ready_mode = 0;

  // stats gathered by the monitor
  int run_cnt = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int last_data = 0;
  logic [BW-1:0] q_cr[$];
  logic [BW-1:0] q_ci[$];

  // reference model: pixel index k within the frame
  bit m_busy = 0, m_wait = 0, m_valid = 0;
  bit exp_run = 0, exp_done = 0;
  int k = 0, mw = 0, mh = 0, m_data = 0;
  logic [BW-1:0] cro, cio, crs, cis;

  function automatic logic [BW-1:0] mcr(int xx);
    return BW'(int'(cro) + xx * int'(crs));
  endfunction

  function automatic logic [BW-1:0] mci(int yy);
    return BW'(int'(cio) + yy * int'(cis));
  endfunction

  // engine: answers each eng_run after lat+1 cycles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_ctr  = CW'(ctr_val);
        eng_cnt  = -1;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
      end
      if (eng_run) begin
        if (rand_eng) begin
          lat     = $urandom_range(0, 6);
          ctr_val = $urandom_range(0, 127);
        end
        eng_cnt = lat;
      end
    end
  end

  // framebuffer ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'($urandom % 2);
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // compare process + model advance
  initial begin
    bit nrun, ndone;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_wait = 0; m_valid = 0;
        exp_run = 0; exp_done = 0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", pix_valid, 0);
      end else begin
        chk("eng_run", eng_run, exp_run);
        chk("busy", busy, m_busy);
        chk("pix_valid", pix_valid, m_valid);
        chk("frame_done", frame_done, exp_done);
        if (m_busy) begin
          chk("eng_cr", eng_cr, mcr(k % mw));
          chk("eng_ci", eng_ci, mci(k / mw));
        end
        if (m_valid) begin
          chk("pix_data", pix_data, m_data);
          chk("pix_first", pix_first, k == 0);
          chk("pix_last", pix_last,
              k == mw * mh - 1);
        end
        if (eng_run) begin
          run_cnt++;
          q_cr.push_back(eng_cr);
          q_ci.push_back(eng_ci);
        end
        if (frame_done) done_cnt++;
        if (pix_valid && pix_ready) begin
          hs_cnt++;
          last_data = pix_data;
        end
        nrun = 0;
        ndone = 0;
        if (abort) begin
          m_busy = 0; m_wait = 0; m_valid = 0;
        end else if (!m_busy) begin
          if (start) begin
            mw = cfg_width; mh = cfg_height;
            cro = cr_origin; cio = ci_origin;
            crs = cr_step; cis = ci_step;
            if (mw == 0 || mh == 0) begin
              ndone = 1;
            end else begin
              m_busy = 1; k = 0; nrun = 1;
            end
          end
        end else if (exp_run) begin
          m_wait = 1;
        end else if (m_wait) begin
          if (eng_done) begin
            m_wait = 0;
            m_valid = 1;
            m_data = eng_ctr > 15 ? 15 : eng_ctr;
          end
        end else if (m_valid && pix_ready) begin
          m_valid = 0;
          if (k == mw * mh - 1) begin
            m_busy = 0; ndone = 1;
          end else begin
            k++; nrun = 1;
          end
        end
        exp_run = nrun;
        exp_done = ndone;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(int w, int h, int cr0, int ci0,
                    int crs0, int cis0);
    cfg_width  = XW'(w);
    cfg_height = YW'(h);
    cr_origin  = BW'(cr0);
    ci_origin  = BW'(ci0);
    cr_step    = BW'(crs0);
    ci_step    = BW'(cis0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_frame(string n, int d0);
    int c = 0;
    while (done_cnt == d0 && c < 600) begin
      cyc(1);
      c++;
    end
    chk(n, done_cnt, d0 + 1);
  endtask

  task automatic wait_valid(string n);
    int c = 0;
    while (!pix_valid && c < 100) begin
      cyc(1);
      c++;
    end
    chk(n, pix_valid, 1);
  endtask

  task automatic clear_stats();
    run_cnt = 0;
    hs_cnt = 0;
    q_cr.delete();
    q_ci.delete();
  endtask

  initial begin
    int d0, rc;
    #1;
    chk("rst_eng_cr", eng_cr, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_done", frame_done, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // basic 2x2 frame, stray start mid-frame
    clear_stats();
    d0 = done_cnt;
    go(2, 2, 'h700, 'h100, 'h010, 'h020);
    cyc(8);
    go(5, 3, 0, 0, 1, 1);
    wait_frame("t1_done", d0);
    cyc(3);
    chk("t1_runs", run_cnt, 4);
    chk("t1_hs", hs_cnt, 4);
    chk("t1_cr0", q_cr[0], 'h700);
    chk("t1_ci0", q_ci[0], 'h100);
    chk("t1_cr1", q_cr[1], 'h710);
    chk("t1_cr2", q_cr[2], 'h700);
    chk("t1_ci2", q_ci[2], 'h120);
    chk("t1_cr3", q_cr[3], 'h710);
    chk("t1_ci3", q_ci[3], 'h120);
    chk("t1_data", last_data, 3);
    chk("t1_one_done", done_cnt, d0 + 1);

    // wrap of cr
    clear_stats();
    d0 = done_cnt;
    go(2, 1, 'h7F8, 0, 'h010, 0);
    wait_frame("t2_done", d0);
    chk("t2_wrap", q_cr[1], 'h008);

    // backpressure + saturation
    clear_stats();
    ctr_val = 'h7F;
    ready_mode = 2;
    d0 = done_cnt;
    go(1, 1, 'h123, 'h456, 1, 1);
    wait_valid("t3_valid");
    rc = run_cnt;
    cyc(10);
    chk("t3_no_run", run_cnt, rc);
    chk("t3_sat", pix_data, 'hF);
    ready_mode = 0;
    wait_frame("t3_done", d0);

    // abort in WAIT, late eng_done ignored
    ctr_val = 5;
    d0 = done_cnt;
    go(2, 2, 'h040, 'h050, 'h001, 'h002);
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    cyc(10);
    chk("t4_valid", pix_valid, 0);
    chk("t4_no_done", done_cnt, d0);

    // abort in OUT, then full restart
    ready_mode = 2;
    go(2, 2, 'h040, 'h050, 'h001, 'h002);
    wait_valid("t5_valid");
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", pix_valid, 0);
    ready_mode = 0;
    cyc(8);
    clear_stats();
    d0 = done_cnt;
    go(2, 2, 'h040, 'h050, 'h001, 'h002);
    wait_frame("t5_done", d0);
    chk("t5_cr0", q_cr[0], 'h040);
    chk("t5_ci0", q_ci[0], 'h050);
    chk("t5_runs", run_cnt, 4);

    // empty frame; start+abort together
    clear_stats();
    d0 = done_cnt;
    go(0, 3, 1, 1, 1, 1);
    cyc(3);
    chk("t6_done", done_cnt, d0 + 1);
    chk("t6_runs", run_cnt, 0);
    abort = 1'b1;
    go(2, 2, 1, 1, 1, 1);
    abort = 1'b0;
    cyc(3);
    chk("t6_abort_win", run_cnt, 0);

    // random frames
    rand_eng = 1'b1;
    for (int f = 0; f < 10; f++) begin
      ready_mode = $urandom_range(0, 1);
      d0 = done_cnt;
      go($urandom_range(1, 4), $urandom_range(1, 3),
         $urandom_range(0, 2047),
         $urandom_range(0, 2047),
         $urandom_range(0, 2047),
         $urandom_range(0, 2047));
      wait_frame("rand_done", d0);
    end

    // async reset mid-frame
    ready_mode = 0;
    go(3, 3, 'h100, 'h200, 'h011, 'h022);
    cyc(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_run", eng_run, 0);
    chk("ar_valid", pix_valid, 0);
    chk("ar_cr", eng_cr, 0);
    chk("ar_ci", eng_ci, 0);
    chk("ar_data", pix_data, 0);
    chk("ar_flags", {pix_first, pix_last}, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    d0 = done_cnt;
    go(2, 1, 'h300, 'h010, 'h005, 0);
    wait_frame("ar_after", d0);

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
